// File: rtl/aes_pkg.sv
// aes_pkg: shared AES block geometry, round counts per key length and the
// round-sequencer state encoding.
//   AES_WORD / AES_NB : default word width and words per block
//   NR_128/192/256    : cipher rounds for each key length
//   RND_W             : width of the round counter / round-key index
//   seq_state_e       : sequencer FSM states
package aes_pkg;

    localparam int unsigned AES_WORD = 32;
    localparam int unsigned AES_NB   = 4;

    localparam int unsigned NR_128 = 10;
    localparam int unsigned NR_192 = 12;
    localparam int unsigned NR_256 = 14;

    localparam int unsigned RND_W = 4;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        KEY0  = 2'd1,
        ROUND = 2'd2,
        DONE  = 2'd3
    } seq_state_e;

endpackage

// File: rtl/aes_round_seq.sv
// aes_round_seq: AES encryption round sequencer. Accepts one plaintext block,
// applies the initial AddRoundKey, then iterates an external round datapath
// NR times, XORing each round result with the matching round key fetched from
// an external key schedule. The final ciphertext is held until consumed.
// Ports:
//   i_clk, i_rst                 clock, asynchronous active-high reset
//   i_valid/o_ready/i_block      plaintext handshake
//   o_valid/i_ready/o_block      ciphertext handshake (o_block mirrors state)
//   o_rk_req/o_rk_idx            round-key request and index 0..NR
//   i_rk_valid/i_rk              round key returned by the key schedule
//   o_rnd_valid/o_rnd_final      state offered to round datapath; final round
//   o_rnd_block                  state sent to the round datapath
//   i_rnd_valid/i_rnd_block      round datapath result
module aes_round_seq
    import aes_pkg::*;
#(
    parameter int unsigned WORD = AES_WORD,
    parameter int unsigned NB   = AES_NB,
    parameter int unsigned NR   = NR_128
) (
    input  logic                 i_clk,
    input  logic                 i_rst,
    input  logic                 i_valid,
    output logic                 o_ready,
    input  logic [WORD*NB-1:0]   i_block,
    output logic                 o_valid,
    input  logic                 i_ready,
    output logic [WORD*NB-1:0]   o_block,
    output logic                 o_rk_req,
    output logic [RND_W-1:0]     o_rk_idx,
    input  logic                 i_rk_valid,
    input  logic [WORD*NB-1:0]   i_rk,
    output logic                 o_rnd_valid,
    output logic                 o_rnd_final,
    output logic [WORD*NB-1:0]   o_rnd_block,
    input  logic                 i_rnd_valid,
    input  logic [WORD*NB-1:0]   i_rnd_block
);

    localparam int unsigned      BLK_W    = WORD * NB;
    localparam logic [RND_W-1:0] RND_LAST = RND_W'(NR);

    // Only the three standard AES round counts are meaningful.
    if (NR != NR_128 && NR != NR_192 && NR != NR_256) begin : g_nr_check
        $error("aes_round_seq: NR must be 10, 12 or 14");
    end

    seq_state_e        fsm_q;
    seq_state_e        fsm_d;
    logic [RND_W-1:0]  rnd_q;
    logic [RND_W-1:0]  rnd_d;
    logic [BLK_W-1:0]  state_q;
    logic [BLK_W-1:0]  state_d;

    logic              ready_d;
    logic              valid_d;
    logic              rk_req_d;
    logic [RND_W-1:0]  rk_idx_d;
    logic              rnd_valid_d;
    logic              rnd_final_d;

    // State register and registered handshake outputs.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            fsm_q       <= IDLE;
            rnd_q       <= '0;
            state_q     <= '0;
            o_ready     <= 1'b1;
            o_valid     <= 1'b0;
            o_rk_req    <= 1'b0;
            o_rk_idx    <= '0;
            o_rnd_valid <= 1'b0;
            o_rnd_final <= 1'b0;
        end else begin
            fsm_q       <= fsm_d;
            rnd_q       <= rnd_d;
            state_q     <= state_d;
            o_ready     <= ready_d;
            o_valid     <= valid_d;
            o_rk_req    <= rk_req_d;
            o_rk_idx    <= rk_idx_d;
            o_rnd_valid <= rnd_valid_d;
            o_rnd_final <= rnd_final_d;
        end
    end

    // Next-state, round counter, AddRoundKey and next output values.
    always_comb begin
        fsm_d       = fsm_q;
        rnd_d       = rnd_q;
        state_d     = state_q;
        ready_d     = 1'b0;
        valid_d     = 1'b0;
        rk_req_d    = 1'b0;
        rk_idx_d    = '0;
        rnd_valid_d = 1'b0;
        rnd_final_d = 1'b0;

        unique case (fsm_q)
            IDLE: begin
                if (i_valid && o_ready) begin
                    state_d = i_block;
                    rnd_d   = '0;
                    fsm_d   = KEY0;
                end
            end
            KEY0: begin
                if (i_rk_valid) begin
                    state_d = state_q ^ i_rk;
                    rnd_d   = RND_W'(1);
                    fsm_d   = ROUND;
                end
            end
            ROUND: begin
                // Both the key and the round result must be present together;
                // otherwise everything holds.
                if (i_rk_valid && i_rnd_valid) begin
                    state_d = i_rnd_block ^ i_rk;
                    if (rnd_q == RND_LAST) begin
                        fsm_d = DONE;
                    end else begin
                        rnd_d = rnd_q + RND_W'(1);
                    end
                end
            end
            DONE: begin
                if (i_ready) begin
                    fsm_d = IDLE;
                end
            end
            default: begin
                fsm_d = IDLE;
            end
        endcase

        // Outputs are decoded from the next state so they register in step
        // with the FSM.
        ready_d     = (fsm_d == IDLE);
        valid_d     = (fsm_d == DONE);
        rk_req_d    = (fsm_d == KEY0) || (fsm_d == ROUND);
        rk_idx_d    = (fsm_d == ROUND) ? rnd_d : '0;
        rnd_valid_d = (fsm_d == ROUND);
        rnd_final_d = (fsm_d == ROUND) && (rnd_d == RND_LAST);
    end

    assign o_block     = state_q;
    assign o_rnd_block = state_q;

endmodule

// File: tb/tb_aes_round_seq.sv
// tb_aes_round_seq: scoreboard bench for aes_round_seq. Provides a behavioural
// AES round datapath and key schedule around two sequencer instances
// (NR=10 with an AES-128 key, NR=14 with an AES-256 key) and checks the
// FIPS-197 appendix C ciphertexts, latency, stalls, back-pressure and reset.
`timescale 1ns/1ps
module tb_aes_round_seq;

    localparam logic [127:0] PT     = 128'h00112233445566778899aabbccddeeff;
    localparam logic [127:0] CT_128 = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
    localparam logic [127:0] CT_256 = 128'h8ea2b7ca516745bfeafc49904b496089;

    localparam logic [2047:0] SBOX = {
        128'h637c777bf26b6fc53001672bfed7ab76, 128'hca82c97dfa5947f0add4a2af9ca472c0,
        128'hb7fd9326363ff7cc34a5e5f171d83115, 128'h04c723c31896059a071280e2eb27b275,
        128'h09832c1a1b6e5aa0523bd6b329e32f84, 128'h53d100ed20fcb15b6acbbe394a4c58cf,
        128'hd0efaafb434d338545f9027f503c9fa8, 128'h51a3408f929d38f5bcb6da2110fff3d2,
        128'hcd0c13ec5f974417c4a77e3d645d1973, 128'h60814fdc222a908846eeb814de5e0bdb,
        128'he0323a0a4906245cc2d3ac629195e479, 128'he7c8376d8dd54ea96c56f4ea657aae08,
        128'hba78252e1ca6b4c6e8dd741f4bbd8b8a, 128'h703eb5664803f60e613557b986c11d9e,
        128'he1f8981169d98e949b1e87e9ce5528df, 128'h8ca1890dbfe6426841992d0fb054bb16};

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    logic         in_valid_a = 1'b0, ready_a, out_valid_a, out_ready_a = 1'b1;
    logic         rk_req_a, rk_valid_a = 1'b1, rnd_req_a, rnd_final_a, rnd_valid_a = 1'b1;
    logic [3:0]   rk_idx_a;
    logic [127:0] in_block_a = '0, out_block_a, rk_a, rnd_out_a, rnd_in_a;

    logic         in_valid_b = 1'b0, ready_b, out_valid_b, out_ready_b = 1'b1;
    logic         rk_req_b, rk_valid_b = 1'b1, rnd_req_b, rnd_final_b, rnd_valid_b = 1'b1;
    logic [3:0]   rk_idx_b;
    logic [127:0] in_block_b = '0, out_block_b, rk_b, rnd_out_b, rnd_in_b;

    logic [127:0] rk_tab_a [11];
    logic [127:0] rk_tab_b [15];
    logic [31:0]  kw [60];

    logic [127:0] exp_a [$];
    logic [127:0] exp_b [$];

    int n_vec  = 0;
    int n_fail = 0;
    bit rand_mode = 1'b0;

    aes_round_seq #(.WORD(32), .NB(4), .NR(10)) dut_a (
        .i_clk(clk), .i_rst(rst),
        .i_valid(in_valid_a), .o_ready(ready_a), .i_block(in_block_a),
        .o_valid(out_valid_a), .i_ready(out_ready_a), .o_block(out_block_a),
        .o_rk_req(rk_req_a), .o_rk_idx(rk_idx_a), .i_rk_valid(rk_valid_a), .i_rk(rk_a),
        .o_rnd_valid(rnd_req_a), .o_rnd_final(rnd_final_a), .o_rnd_block(rnd_out_a),
        .i_rnd_valid(rnd_valid_a), .i_rnd_block(rnd_in_a));

    aes_round_seq #(.WORD(32), .NB(4), .NR(14)) dut_b (
        .i_clk(clk), .i_rst(rst),
        .i_valid(in_valid_b), .o_ready(ready_b), .i_block(in_block_b),
        .o_valid(out_valid_b), .i_ready(out_ready_b), .o_block(out_block_b),
        .o_rk_req(rk_req_b), .o_rk_idx(rk_idx_b), .i_rk_valid(rk_valid_b), .i_rk(rk_b),
        .o_rnd_valid(rnd_req_b), .o_rnd_final(rnd_final_b), .o_rnd_block(rnd_out_b),
        .i_rnd_valid(rnd_valid_b), .i_rnd_block(rnd_in_b));

    function automatic logic [7:0] sbox(input logic [7:0] x);
        int idx;
        idx = 2047 - 8 * int'(x);
        return SBOX[idx -: 8];
    endfunction

    function automatic logic [7:0] xt(input logic [7:0] b);
        return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [31:0] subw(input logic [31:0] w);
        return {sbox(w[31:24]), sbox(w[23:16]), sbox(w[15:8]), sbox(w[7:0])};
    endfunction

    // SubBytes, ShiftRows and (unless final) MixColumns on a column-major state.
    function automatic logic [127:0] aes_round(input logic [127:0] s, input logic fin);
        logic [7:0]   a [16];
        logic [7:0]   t [16];
        logic [7:0]   c0, c1, c2, c3;
        logic [127:0] r;
        for (int i = 0; i < 16; i++) a[i] = sbox(s[127-8*i -: 8]);
        for (int c = 0; c < 4; c++)
            for (int w = 0; w < 4; w++)
                t[4*c+w] = a[4*((c+w)%4)+w];
        for (int c = 0; c < 4; c++) begin
            c0 = t[4*c]; c1 = t[4*c+1]; c2 = t[4*c+2]; c3 = t[4*c+3];
            if (!fin) begin
                t[4*c]   = xt(c0) ^ xt(c1) ^ c1 ^ c2 ^ c3;
                t[4*c+1] = c0 ^ xt(c1) ^ xt(c2) ^ c2 ^ c3;
                t[4*c+2] = c0 ^ c1 ^ xt(c2) ^ xt(c3) ^ c3;
                t[4*c+3] = xt(c0) ^ c0 ^ c1 ^ c2 ^ xt(c3);
            end
        end
        for (int i = 0; i < 16; i++) r[127-8*i -: 8] = t[i];
        return r;
    endfunction

    task automatic expand(input logic [255:0] key, input int nk, input int nr);
        logic [31:0] tmp;
        logic [7:0]  rc;
        rc = 8'h01;
        for (int i = 0; i < nk; i++) kw[i] = key[255-32*i -: 32];
        for (int i = nk; i < 4*(nr+1); i++) begin
            tmp = kw[i-1];
            if (i % nk == 0) begin
                tmp = subw({tmp[23:0], tmp[31:24]}) ^ {rc, 24'h0};
                rc  = xt(rc);
            end else if (nk > 6 && i % nk == 4) begin
                tmp = subw(tmp);
            end
            kw[i] = kw[i-nk] ^ tmp;
        end
    endtask

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, wanted %h", name, act, exp);
        end
    endtask

    // External key schedule and round datapath.
    always_comb begin
        rk_a     = (rk_idx_a <= 4'd10) ? rk_tab_a[rk_idx_a] : '0;
        rk_b     = (rk_idx_b <= 4'd14) ? rk_tab_b[rk_idx_b] : '0;
        rnd_in_a = aes_round(rnd_out_a, rnd_final_a);
        rnd_in_b = aes_round(rnd_out_b, rnd_final_b);
    end

    // Offer a block, push its ciphertext, wait for o_valid; lat counts cycles.
    task automatic send(input bit sel_b, input logic [127:0] pt, input logic [127:0] ct,
                        output int lat);
        int n;
        n = 0;
        while ((sel_b ? ready_b : ready_a) !== 1'b1 && n < 100) begin
            @(negedge clk);
            n++;
        end
        if (sel_b) begin
            check("accept_ready_b", 128'(ready_b), 128'(1));
            in_valid_b = 1'b1; in_block_b = pt; exp_b.push_back(ct);
        end else begin
            check("accept_ready_a", 128'(ready_a), 128'(1));
            in_valid_a = 1'b1; in_block_a = pt; exp_a.push_back(ct);
        end
        @(negedge clk);
        in_valid_a = 1'b0;
        in_valid_b = 1'b0;
        lat = 1;
        while ((sel_b ? out_valid_b : out_valid_a) !== 1'b1 && lat < 400) begin
            @(negedge clk);
            lat++;
        end
        if (sel_b) check("done_b", 128'(out_valid_b), 128'(1));
        else       check("done_a", 128'(out_valid_a), 128'(1));
    endtask

    // Scoreboard monitor: pop on o_valid rising, then require a stable o_block.
    initial begin : monitor
        logic [127:0] cur_a, cur_b;
        bit seen_a, seen_b;
        seen_a = 1'b0; seen_b = 1'b0; cur_a = '0; cur_b = '0;
        forever begin
            @(negedge clk);
            if (out_valid_a === 1'b1) begin
                if (!seen_a) begin
                    if (exp_a.size() == 0) check("spurious_a", 128'(out_valid_a), 128'(0));
                    else begin
                        cur_a = exp_a.pop_front();
                        check("ciphertext_a", out_block_a, cur_a);
                    end
                    seen_a = 1'b1;
                end else check("stable_a", out_block_a, cur_a);
            end else seen_a = 1'b0;
            if (out_valid_b === 1'b1) begin
                if (!seen_b) begin
                    if (exp_b.size() == 0) check("spurious_b", 128'(out_valid_b), 128'(0));
                    else begin
                        cur_b = exp_b.pop_front();
                        check("ciphertext_b", out_block_b, cur_b);
                    end
                    seen_b = 1'b1;
                end else check("stable_b", out_block_b, cur_b);
            end else seen_b = 1'b0;
        end
    end

    // Drives key/round valids (random or tied high) and checks stalls freeze.
    initial begin : valid_driver
        logic [127:0] prev_blk;
        logic [3:0]   prev_idx;
        bit           prev_stall, rkv, rdv;
        prev_stall = 1'b0; prev_blk = '0; prev_idx = '0;
        forever begin
            @(negedge clk);
            if (prev_stall) begin
                check("stall_state", rnd_out_a, prev_blk);
                check("stall_rnd", 128'(rk_idx_a), 128'(prev_idx));
                check("stall_req", 128'(rnd_req_a), 128'(1));
            end
            if (rnd_req_a || rnd_final_a)
                check("final_a", 128'(rnd_final_a), 128'(rnd_req_a && rk_idx_a == 4'd10));
            if (rnd_req_b || rnd_final_b)
                check("final_b", 128'(rnd_final_b), 128'(rnd_req_b && rk_idx_b == 4'd14));
            rkv = rand_mode ? ($urandom_range(0, 99) < 50) : 1'b1;
            rdv = rand_mode ? ($urandom_range(0, 99) < 70) : 1'b1;
            rk_valid_a  = rkv;
            rnd_valid_a = rdv;
            prev_stall  = rnd_req_a && !(rkv && rdv);
            prev_blk    = rnd_out_a;
            prev_idx    = rk_idx_a;
        end
    end

    initial begin : watchdog
        #2000000;
        $display("FAIL watchdog: simulation did not finish, %0d miscompares so far", n_fail);
        $fatal(1, "watchdog expired");
    end

    initial begin : stimulus
        int lat, n;
        expand({128'h000102030405060708090a0b0c0d0e0f, 128'h0}, 4, 10);
        for (int k = 0; k < 11; k++) rk_tab_a[k] = {kw[4*k], kw[4*k+1], kw[4*k+2], kw[4*k+3]};
        expand(256'h000102030405060708090a0b0c0d0e0f101112131415161718191a1b1c1d1e1f, 8, 14);
        for (int k = 0; k < 15; k++) rk_tab_b[k] = {kw[4*k], kw[4*k+1], kw[4*k+2], kw[4*k+3]};

        #1 rst = 1'b1;
        repeat (3) @(negedge clk);
        check("rst_ready", 128'(ready_a), 128'(1));
        check("rst_valid", 128'(out_valid_a), 128'(0));
        check("rst_block", out_block_a, 128'(0));
        check("rst_rk_req", 128'(rk_req_a), 128'(0));
        check("rst_rk_idx", 128'(rk_idx_a), 128'(0));
        check("rst_rnd_valid", 128'(rnd_req_a), 128'(0));
        check("rst_rnd_final", 128'(rnd_final_a), 128'(0));
        check("rst_rnd_block", rnd_out_a, 128'(0));
        check("rst_ready_b", 128'(ready_b), 128'(1));
        check("rst_rk_req_b", 128'(rk_req_b), 128'(0));

        // First accept on the first edge after reset release; NR+2 latency.
        rst = 1'b0;
        send(1'b0, PT, CT_128, lat);
        check("latency_first", 128'(lat), 128'(12));
        @(negedge clk);
        check("ready_after_done", 128'(ready_a), 128'(1));
        check("valid_after_done", 128'(out_valid_a), 128'(0));
        send(1'b0, PT, CT_128, lat);
        check("latency_b2b", 128'(lat), 128'(12));

        // Random key and round-datapath stalls.
        @(negedge clk);
        rand_mode = 1'b1;
        repeat (3) send(1'b0, PT, CT_128, lat);
        @(negedge clk);
        rand_mode   = 1'b0;
        out_ready_a = 1'b0;
        @(negedge clk);

        // Back-pressure in DONE with ignored plaintext offers.
        send(1'b0, PT, CT_128, lat);
        check("latency_hold", 128'(lat), 128'(12));
        for (int i = 0; i < 5; i++) begin
            check("hold_valid", 128'(out_valid_a), 128'(1));
            check("hold_block", out_block_a, CT_128);
            check("hold_ready", 128'(ready_a), 128'(0));
            check("hold_rk_req", 128'(rk_req_a), 128'(0));
            check("hold_rk_idx", 128'(rk_idx_a), 128'(0));
            in_valid_a = (i % 2 == 0);
            in_block_a = 128'hdeadbeef_cafef00d_01234567_89abcdef;
            @(negedge clk);
        end
        in_valid_a  = 1'b0;
        out_ready_a = 1'b1;
        @(negedge clk);
        check("release_valid", 128'(out_valid_a), 128'(0));
        check("release_ready", 128'(ready_a), 128'(1));
        check("release_rk_req", 128'(rk_req_a), 128'(0));
        check("release_block", out_block_a, CT_128);

        // Reset in the middle of round 5, then a fresh block.
        in_valid_a = 1'b1;
        in_block_a = PT;
        exp_a.push_back(CT_128);
        @(negedge clk);
        in_valid_a = 1'b0;
        n = 0;
        while (!(rnd_req_a && rk_idx_a == 4'd5) && n < 50) begin
            @(negedge clk);
            n++;
        end
        check("reach_rnd5", 128'(rk_idx_a), 128'(5));
        rst = 1'b1;
        void'(exp_a.pop_back());
        #1;
        check("midrst_ready", 128'(ready_a), 128'(1));
        check("midrst_valid", 128'(out_valid_a), 128'(0));
        check("midrst_block", out_block_a, 128'(0));
        check("midrst_rnd_valid", 128'(rnd_req_a), 128'(0));
        check("midrst_rk_idx", 128'(rk_idx_a), 128'(0));
        @(negedge clk);
        rst = 1'b0;
        send(1'b0, PT, CT_128, lat);
        check("latency_after_rst", 128'(lat), 128'(12));

        // 14-round sequencer with the AES-256 key schedule.
        send(1'b1, PT, CT_256, lat);
        check("latency_nr14", 128'(lat), 128'(16));

        repeat (3) @(negedge clk);
        check("left_a", 128'(exp_a.size()), 128'(0));
        check("left_b", 128'(exp_b.size()), 128'(0));
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

endmodule
